// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port unified memory between instruction fetch
//            (IF) and the load/store path (LS). One access in flight at a time
//            (IDLE -> ISSUE -> RESP). LS has priority, but a streak counter
//            caps consecutive LS grants while IF waits. A per-access timeout
//            completes a hung access with an error instead of stalling.
// Ports    : i_clk/i_rst          clock, synchronous active-high reset
//            i_if_*  / o_if_*     fetch request, ack pulse, error, read data
//            i_ls_*  / o_ls_*     load/store request, ack pulse, error, data
//            o_mem_* / i_mem_*    registered memory request, req/ack handshake
//            o_busy               high whenever an access is in progress
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int LS_MAX  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_ack,
    output logic          o_if_err,
    output logic [31:0]   o_if_rdata,
    input  logic          i_ls_req,
    input  logic          i_ls_wren,
    input  logic [AW-1:0] i_ls_addr,
    input  logic [31:0]   i_ls_wdata,
    input  logic [3:0]    i_ls_bmask,
    output logic          o_ls_ack,
    output logic          o_ls_err,
    output logic [31:0]   o_ls_rdata,
    output logic          o_mem_req,
    output logic          o_mem_wren,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [3:0]    o_mem_bmask,
    input  logic          i_mem_ack,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_busy
);

    localparam int C_SW = $clog2(LS_MAX + 1);
    localparam int C_TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t          r_state_q,     w_state_d;
    logic            r_owner_ls_q,  w_owner_ls_d;
    logic            r_wren_q,      w_wren_d;
    logic [AW-1:0]   r_addr_q,      w_addr_d;
    logic [31:0]     r_wdata_q,     w_wdata_d;
    logic [3:0]      r_bmask_q,     w_bmask_d;
    logic [C_SW-1:0] r_streak_q,    w_streak_d;
    logic [C_TW-1:0] r_tmo_q,       w_tmo_d;
    logic            r_err_q,       w_err_d;
    logic [31:0]     r_rdata_q,     w_rdata_d;
    logic            w_grant_ls;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= ST_IDLE;
            r_owner_ls_q <= 1'b0;
            r_wren_q     <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_bmask_q    <= '0;
            r_streak_q   <= '0;
            r_tmo_q      <= '0;
            r_err_q      <= 1'b0;
            r_rdata_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_owner_ls_q <= w_owner_ls_d;
            r_wren_q     <= w_wren_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_bmask_q    <= w_bmask_d;
            r_streak_q   <= w_streak_d;
            r_tmo_q      <= w_tmo_d;
            r_err_q      <= w_err_d;
            r_rdata_q    <= w_rdata_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_owner_ls_d = r_owner_ls_q;
        w_wren_d     = r_wren_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_bmask_d    = r_bmask_q;
        w_streak_d   = r_streak_q;
        w_tmo_d      = r_tmo_q;
        w_err_d      = r_err_q;
        w_rdata_d    = r_rdata_q;
        // LS wins unless IF has already waited through LS_MAX LS grants.
        w_grant_ls   = i_ls_req && !(i_if_req && (r_streak_q == C_SW'(LS_MAX)));

        case (r_state_q)
            ST_IDLE: begin
                if (i_ls_req || i_if_req) begin
                    w_state_d    = ST_ISSUE;
                    w_owner_ls_d = w_grant_ls;
                    w_wren_d     = w_grant_ls & i_ls_wren;
                    w_addr_d     = w_grant_ls ? i_ls_addr  : i_if_addr;
                    w_wdata_d    = w_grant_ls ? i_ls_wdata : 32'd0;
                    w_bmask_d    = w_grant_ls ? i_ls_bmask : 4'hF;
                    w_tmo_d      = '0;
                    w_err_d      = 1'b0;
                    w_rdata_d    = '0;
                    // Streak only counts LS grants that made a waiting IF wait longer.
                    if (w_grant_ls && i_if_req) begin
                        if (r_streak_q != C_SW'(LS_MAX)) begin
                            w_streak_d = r_streak_q + 1'b1;
                        end
                    end else begin
                        w_streak_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                // An ack in the final allowed cycle still counts as success.
                if (i_mem_ack) begin
                    w_state_d = ST_RESP;
                    w_err_d   = 1'b0;
                    w_rdata_d = r_wren_q ? 32'd0 : i_mem_rdata;
                end else if (r_tmo_q == C_TW'(TIMEOUT - 1)) begin
                    w_state_d = ST_RESP;
                    w_err_d   = 1'b1;
                    w_rdata_d = '0;
                end else begin
                    w_tmo_d = r_tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                w_state_d = ST_IDLE;
                w_err_d   = 1'b0;
                w_rdata_d = '0;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign o_mem_req   = (r_state_q == ST_ISSUE);
    assign o_mem_wren  = r_wren_q;
    assign o_mem_addr  = r_addr_q;
    assign o_mem_wdata = r_wdata_q;
    assign o_mem_bmask = r_bmask_q;
    assign o_busy      = (r_state_q != ST_IDLE);

    assign o_if_ack    = (r_state_q == ST_RESP) && !r_owner_ls_q;
    assign o_ls_ack    = (r_state_q == ST_RESP) &&  r_owner_ls_q;
    assign o_if_err    = o_if_ack & r_err_q;
    assign o_ls_err    = o_ls_ack & r_err_q;
    assign o_if_rdata  = o_if_ack ? r_rdata_q : 32'd0;
    assign o_ls_rdata  = o_ls_ack ? r_rdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. Inputs change
//            and outputs are sampled on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_wren, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_bmask;
    logic        if_ack, if_err, ls_ack, ls_err, mem_req, mem_wren, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_bmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .LS_MAX(4), .TIMEOUT(64)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .o_if_ack   (if_ack),
        .o_if_err   (if_err),
        .o_if_rdata (if_rdata),
        .i_ls_req   (ls_req),
        .i_ls_wren  (ls_wren),
        .i_ls_addr  (ls_addr),
        .i_ls_wdata (ls_wdata),
        .i_ls_bmask (ls_bmask),
        .o_ls_ack   (ls_ack),
        .o_ls_err   (ls_err),
        .o_ls_rdata (ls_rdata),
        .o_mem_req  (mem_req),
        .o_mem_wren (mem_wren),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_bmask(mem_bmask),
        .i_mem_ack  (mem_ack),
        .i_mem_rdata(mem_rdata),
        .o_busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the arbiter to present a memory request.
    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, mem_req}, 32'd1);
    endtask

    initial begin
        int n;
        logic exp_ls;
        rst = 1'b1; if_req = 0; ls_req = 0; ls_wren = 0; mem_ack = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; ls_bmask = 0;
        repeat (2) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_busy",    {31'd0, busy}, 0);
        check("rst_acks",    {30'd0, if_ack, ls_ack}, 0);
        check("rst_addr",    mem_addr, 0);
        check("rst_bmask",   {28'd0, mem_bmask}, 0);
        rst = 1'b0;

        // ---------------- IF only, ack in first ISSUE cycle ----------------
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        check("if_mem_req",   {31'd0, mem_req}, 1);
        check("if_mem_addr",  mem_addr, 32'h100);
        check("if_mem_bmask", {28'd0, mem_bmask}, 32'hF);
        check("if_mem_wren",  {31'd0, mem_wren}, 0);
        check("if_busy",      {31'd0, busy}, 1);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        check("if_ack",      {31'd0, if_ack}, 1);
        check("if_err",      {31'd0, if_err}, 0);
        check("if_rdata",    if_rdata, 32'h0050_0093);
        check("if_ls_ack",   {31'd0, ls_ack}, 0);
        check("if_resp_req", {31'd0, mem_req}, 0);
        if_req = 0; mem_ack = 0;
        @(negedge clk);
        check("if_idle_ack",  {31'd0, if_ack}, 0);
        check("if_idle_busy", {31'd0, busy}, 0);

        // ---------------- simultaneous IF + LS store ----------------
        if_req = 1; ls_req = 1; ls_wren = 1; ls_addr = 32'h200;
        ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'b0011;
        @(negedge clk);
        check("both_addr",  mem_addr, 32'h200);
        check("both_wren",  {31'd0, mem_wren}, 1);
        check("both_bmask", {28'd0, mem_bmask}, 32'h3);
        check("both_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        check("both_ls_ack",   {31'd0, ls_ack}, 1);
        check("both_ls_rdata", ls_rdata, 0);
        check("both_if_ack",   {31'd0, if_ack}, 0);
        ls_req = 0; ls_wren = 0; mem_ack = 0;
        @(negedge clk);
        wait_req("both_if_wait");
        check("both_if_addr", mem_addr, 32'h100);
        check("both_if_wren", {31'd0, mem_wren}, 0);
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("both_if_ack",   {31'd0, if_ack}, 1);
        check("both_if_rdata", if_rdata, 32'h1234_5678);
        if_req = 0; mem_ack = 0;
        @(negedge clk);

        // ---------------- starvation guard: LS,LS,LS,LS,IF,LS ----------------
        if_req = 1; ls_req = 1; ls_wren = 0; ls_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            exp_ls = (i != 4);
            wait_req($sformatf("strk_wait%0d", i));
            check($sformatf("strk_addr%0d", i), mem_addr, exp_ls ? 32'h300 : 32'h100);
            mem_ack = 1; mem_rdata = 32'hA000_0000 + i;
            @(negedge clk);
            check($sformatf("strk_ls_ack%0d", i), {31'd0, ls_ack}, {31'd0, exp_ls});
            check($sformatf("strk_if_ack%0d", i), {31'd0, if_ack}, {31'd0, !exp_ls});
            check($sformatf("strk_rdata%0d", i), exp_ls ? ls_rdata : if_rdata, 32'hA000_0000 + i);
            mem_ack = 0;
            if (i == 5) begin
                if_req = 0; ls_req = 0;
            end
        end
        @(negedge clk);

        // ---------------- timeout, then late ack ignored ----------------
        if_req = 1; if_addr = 32'h108; mem_rdata = 32'hCAFE_F00D;
        wait_req("tmo_wait");
        n = 0;
        while (mem_req === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("tmo_issue_cycles", n, 64);
        check("tmo_ack",   {31'd0, if_ack}, 1);
        check("tmo_err",   {31'd0, if_err}, 1);
        check("tmo_rdata", if_rdata, 0);
        if_req = 0;
        repeat (4) @(negedge clk);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        check("late_busy", {31'd0, busy}, 0);
        check("late_ack",  {30'd0, if_ack, ls_ack}, 0);
        check("late_req",  {31'd0, mem_req}, 0);

        // ---------------- ack on exactly the timeout cycle ----------------
        if_req = 1; if_addr = 32'h104;
        wait_req("edge_wait");
        repeat (63) @(negedge clk);
        check("edge_still_issue", {31'd0, mem_req}, 1);
        mem_ack = 1; mem_rdata = 32'h0BAD_C0DE;
        @(negedge clk);
        check("edge_ack",   {31'd0, if_ack}, 1);
        check("edge_err",   {31'd0, if_err}, 0);
        check("edge_rdata", if_rdata, 32'h0BAD_C0DE);
        if_req = 0; mem_ack = 0;
        @(negedge clk);

        // ---------------- reset in the middle of an access ----------------
        ls_req = 1; ls_wren = 0; ls_addr = 32'h400;
        wait_req("rst_mid_wait");
        rst = 1;
        @(negedge clk);
        check("rst_mid_req",  {31'd0, mem_req}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_ack",  {31'd0, ls_ack}, 0);
        rst = 0; ls_req = 0;
        @(negedge clk);
        check("rst_post_ack",  {30'd0, ls_ack, if_ack}, 0);
        check("rst_post_busy", {31'd0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
